// File: rtl/oam_sprite_scanner_pkg.sv
// Shared types and constants for the OAM sprite scanner.
// Holds the OAM word layout, the table sizes and the scan FSM state encoding.
package oam_pkg;

  localparam int OAM_ENTRIES = 64;
  localparam int OAM_SLOTS   = 8;
  localparam int OAM_ADDR_W  = 6;

  // One OAM word: [7:0] y, [15:8] tile, [23:16] attr, [31:24] x.
  typedef struct packed {
    logic [7:0] x;
    logic [7:0] attr;
    logic [7:0] tile;
    logic [7:0] y;
  } oam_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } scan_state_e;

  // Mirror a raw row inside an 8- or 16-row sprite.
  function automatic logic [3:0] flip_row(input logic [3:0] raw, input logic tall);
    if (tall) begin
      return 4'd15 - raw;
    end
    return 4'd7 - {1'b0, raw[2:0]};
  endfunction

endpackage

// File: rtl/oam_sprite_scanner_if.sv
// Control, OAM read port and slot read bundle for the sprite scanner.
// slave = scanner side, master = PPU/host side.
interface oam_sprite_scanner_if;
  logic        start;
  logic [7:0]  scanline;
  logic        tall_sprites;
  logic [5:0]  oam_read_addr;
  logic [31:0] oam_read_data;
  logic        busy;
  logic        done;
  logic [3:0]  sprite_count;
  logic        overflow;
  logic [2:0]  slot_index;
  logic [31:0] slot_data;
  logic [3:0]  slot_row;

  modport slave (
    input  start, scanline, tall_sprites, oam_read_data, slot_index,
    output oam_read_addr, busy, done, sprite_count, overflow, slot_data, slot_row
  );

  modport master (
    output start, scanline, tall_sprites, oam_read_data, slot_index,
    input  oam_read_addr, busy, done, sprite_count, overflow, slot_data, slot_row
  );
endinterface

// File: rtl/oam_sprite_scanner_hit_compare.sv
// Combinational scanline-vs-sprite-Y hit test.
// The difference is taken 9 bits wide so sprites below the line (y > scanline)
// show up as a negative result and never wrap into a hit.
module oam_hit_compare (
  input  logic [7:0] scanline_i,
  input  logic [7:0] y_i,
  input  logic       tall_i,
  output logic       hit_o,
  output logic [3:0] row_o
);

  logic [8:0] diff_d;
  logic [7:0] height_d;

  // Row offset and in-range test for the current entry.
  always_comb begin
    diff_d   = {1'b0, scanline_i} - {1'b0, y_i};
    height_d = tall_i ? 8'd16 : 8'd8;
    hit_o    = ~diff_d[8] && (diff_d[7:0] < height_d);
    row_o    = diff_d[3:0];
  end

endmodule

// File: rtl/oam_sprite_scanner.sv
// Per-scanline sprite evaluation: walks all 64 OAM entries, keeps the first 8
// hits in ascending index order and flags overflow on a 9th hit.
// The OAM read port has one cycle of latency, so the compare stage trails the
// address by one SCAN cycle and a FLUSH cycle compares the last entry.
// Optional feature: define OAM_SCAN_VFLIP_EN to mirror slot_row for slots
// whose attr bit 7 (vertical flip) is set.
module oam_sprite_scanner
  import oam_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  oam_sprite_scanner_if.slave  bus
);

  localparam logic [OAM_ADDR_W-1:0] LAST_ADDR = OAM_ADDR_W'(OAM_ENTRIES - 1);
  localparam logic [3:0]            FULL_CNT  = 4'(OAM_SLOTS);

  scan_state_e           state_q;
  logic [OAM_ADDR_W-1:0] addr_q;
  logic                  busy_q;
  logic                  done_q;
  logic [3:0]            count_q;
  logic                  ovf_q;
  logic [7:0]            line_q;
  logic                  tall_q;
  logic                  rd_vld_p1_q;

  oam_entry_t            slot_word_q [OAM_SLOTS];
  logic [3:0]            slot_raw_q  [OAM_SLOTS];

  oam_entry_t            entry_d;
  logic                  hit_d;
  logic [3:0]            row_d;
  logic                  cmp_en_d;
  logic                  cmp_hit_d;
  logic                  slots_full_d;

  assign entry_d      = oam_entry_t'(bus.oam_read_data);
  assign cmp_en_d     = ((state_q == ST_SCAN) && rd_vld_p1_q) || (state_q == ST_FLUSH);
  assign cmp_hit_d    = cmp_en_d && hit_d;
  assign slots_full_d = (count_q == FULL_CNT);

  oam_hit_compare u_hit (
    .scanline_i (line_q),
    .y_i        (entry_d.y),
    .tall_i     (tall_q),
    .hit_o      (hit_d),
    .row_o      (row_d)
  );

  // Scan sequencer: address generation, hit counting, overflow and done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      line_q      <= '0;
      tall_q      <= 1'b0;
      rd_vld_p1_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // busy stays up through the done cycle, so a start that lands
          // right on the done pulse is still rejected here.
          done_q <= 1'b0;
          busy_q <= 1'b0;
          if (bus.start && !busy_q) begin
            line_q      <= bus.scanline;
            tall_q      <= bus.tall_sprites;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            addr_q      <= '0;
            rd_vld_p1_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          // First SCAN cycle only launches address 0; data is valid from the next.
          rd_vld_p1_q <= 1'b1;
          if (addr_q == LAST_ADDR) begin
            state_q <= ST_FLUSH;
          end else begin
            addr_q <= addr_q + 1'b1;
          end
        end
        ST_FLUSH: begin
          state_q <= ST_DONE;
        end
        ST_DONE: begin
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase

      // A hit after the buffer is full ends the scan early.
      if (cmp_hit_d) begin
        if (slots_full_d) begin
          ovf_q   <= 1'b1;
          state_q <= ST_DONE;
        end else begin
          count_q <= count_q + 1'b1;
        end
      end
    end
  end

  // Slot buffer fill: each accepted hit goes to the next free slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < OAM_SLOTS; i++) begin
        slot_word_q[i] <= '0;
        slot_raw_q[i]  <= '0;
      end
    end else if (cmp_hit_d && !slots_full_d) begin
      slot_word_q[count_q[2:0]] <= entry_d;
      slot_raw_q[count_q[2:0]]  <= row_d;
    end
  end

  // Slot read port: zero-latency lookup of word and row for the renderer.
  always_comb begin
    bus.slot_data = slot_word_q[bus.slot_index];
`ifdef OAM_SCAN_VFLIP_EN
    if (slot_word_q[bus.slot_index].attr[7]) begin
      bus.slot_row = flip_row(slot_raw_q[bus.slot_index], tall_q);
    end else begin
      bus.slot_row = slot_raw_q[bus.slot_index];
    end
`else
    bus.slot_row  = slot_raw_q[bus.slot_index];
`endif
  end

  assign bus.oam_read_addr = addr_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.sprite_count  = count_q;
  assign bus.overflow      = ovf_q;

endmodule

// File: tb/tb_oam_sprite_scanner.sv
// Directed self-checking bench for oam_sprite_scanner.
// Edge indices are counted by cyc; after a start sampled on edge k the bench
// reads outputs on falling edges, where cyc equals the last rising edge index.
module tb_oam_sprite_scanner;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  logic [31:0] oam_mem [64];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  oam_sprite_scanner_if bus();

  oam_sprite_scanner dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // OAM RAM model: registered read, data valid one cycle after the address.
  always @(posedge clk) bus.oam_read_data <= oam_mem[bus.oam_read_addr];

  function automatic logic [31:0] mk_word(input int idx, input logic [7:0] y, input logic [7:0] attr);
    logic [7:0] x;
    logic [7:0] tile;
    x    = 8'(idx * 3 + 1);
    tile = 8'(idx + 64);
    return {x, attr, tile, y};
  endfunction

  task automatic fill_oam(input logic [7:0] y);
    for (int i = 0; i < 64; i++) oam_mem[i] = mk_word(i, y, 8'h00);
  endtask

  task automatic start_scan(input logic [7:0] line, input logic tall, output int k);
    @(negedge clk);
    bus.start        = 1'b1;
    bus.scanline     = line;
    bus.tall_sprites = tall;
    @(negedge clk);
    bus.start = 1'b0;
    k = cyc;
  endtask

  task automatic wait_done(input int k, output int lat);
    lat = -1;
    for (int n = 0; n < 200; n++) begin
      if (bus.done === 1'b1) begin
        lat = cyc - k;
        break;
      end
      @(negedge clk);
    end
    if (lat < 0) begin
      checks++;
      failures++;
      $display("FAIL done_timeout got=none exp=done within 200 cycles");
    end
  endtask

  task automatic test_reset;
    bus.start = 1'b0; bus.scanline = 8'h00; bus.tall_sprites = 1'b0; bus.slot_index = 3'd0;
    fill_oam(8'hF0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (bus.oam_read_addr !== 6'd0) begin failures++; $display("FAIL rst_addr got=%0d exp=0", bus.oam_read_addr); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", bus.done); end
    checks++; if (bus.sprite_count !== 4'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", bus.sprite_count); end
    checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL rst_ovf got=%b exp=0", bus.overflow); end
    for (int s = 0; s < 8; s++) begin
      bus.slot_index = 3'(s);
      #1;
      checks++; if (bus.slot_data !== 32'h0 || bus.slot_row !== 4'd0) begin
        failures++; $display("FAIL rst_slot%0d got=%h/%0d exp=0/0", s, bus.slot_data, bus.slot_row);
      end
    end
  endtask

  task automatic test_no_hits;
    int k, lat;
    fill_oam(8'hF0);
    start_scan(8'h10, 1'b0, k);
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL nohit_busy_early got=%b exp=1", bus.busy); end
    wait_done(k, lat);
    checks++; if (lat !== 66) begin failures++; $display("FAIL nohit_latency got=%0d exp=66", lat); end
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL nohit_busy_at_done got=%b exp=1", bus.busy); end
    checks++; if (bus.sprite_count !== 4'd0) begin failures++; $display("FAIL nohit_count got=%0d exp=0", bus.sprite_count); end
    checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL nohit_ovf got=%b exp=0", bus.overflow); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      failures++; $display("FAIL nohit_after got=done%b busy%b exp=done0 busy0", bus.done, bus.busy);
    end
  endtask

  task automatic setup_three;
    fill_oam(8'hF0);
    oam_mem[3]  = mk_word(3, 8'h20, 8'h00);
    oam_mem[10] = mk_word(10, 8'h20, 8'h00);
    oam_mem[40] = mk_word(40, 8'h20, 8'h00);
  endtask

  task automatic test_three_hits;
    int k, lat;
    int ids [3];
    ids = '{3, 10, 40};
    setup_three();
    start_scan(8'h25, 1'b0, k);
    wait_done(k, lat);
    checks++; if (lat !== 66) begin failures++; $display("FAIL three_latency got=%0d exp=66", lat); end
    checks++; if (bus.sprite_count !== 4'd3) begin failures++; $display("FAIL three_count got=%0d exp=3", bus.sprite_count); end
    for (int s = 0; s < 3; s++) begin
      bus.slot_index = 3'(s);
      #1;
      checks++; if (bus.slot_data !== mk_word(ids[s], 8'h20, 8'h00)) begin
        failures++; $display("FAIL three_slot%0d_data got=%h exp=%h", s, bus.slot_data, mk_word(ids[s], 8'h20, 8'h00));
      end
      checks++; if (bus.slot_row !== 4'd5) begin failures++; $display("FAIL three_slot%0d_row got=%0d exp=5", s, bus.slot_row); end
    end
    repeat (5) @(negedge clk);
    checks++; if (bus.sprite_count !== 4'd3) begin failures++; $display("FAIL three_count_hold got=%0d exp=3", bus.sprite_count); end
  endtask

  task automatic test_overflow;
    int k, lat;
    fill_oam(8'hF0);
    for (int i = 0; i < 12; i++) oam_mem[i] = mk_word(i, 8'h50, 8'h00);
    start_scan(8'h50, 1'b0, k);
    wait_done(k, lat);
    checks++; if (lat !== 11) begin failures++; $display("FAIL ovf_latency got=%0d exp=11", lat); end
    checks++; if (bus.sprite_count !== 4'd8) begin failures++; $display("FAIL ovf_count got=%0d exp=8", bus.sprite_count); end
    checks++; if (bus.overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", bus.overflow); end
    for (int s = 0; s < 8; s++) begin
      bus.slot_index = 3'(s);
      #1;
      checks++; if (bus.slot_data !== mk_word(s, 8'h50, 8'h00) || bus.slot_row !== 4'd0) begin
        failures++; $display("FAIL ovf_slot%0d got=%h/%0d exp=%h/0", s, bus.slot_data, bus.slot_row, mk_word(s, 8'h50, 8'h00));
      end
    end
  endtask

  task automatic test_edges;
    int k, lat;
    fill_oam(8'hF0);
    oam_mem[5]  = mk_word(5, 8'h30, 8'h00);
    oam_mem[63] = mk_word(63, 8'h30, 8'h00);
    // Last row of an 8-row sprite, plus entry 63 compared in the flush cycle.
    start_scan(8'h37, 1'b0, k);
    wait_done(k, lat);
    checks++; if (bus.sprite_count !== 4'd2) begin failures++; $display("FAIL edge37_count got=%0d exp=2", bus.sprite_count); end
    checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL edge37_ovf_cleared got=%b exp=0", bus.overflow); end
    bus.slot_index = 3'd0; #1;
    checks++; if (bus.slot_row !== 4'd7) begin failures++; $display("FAIL edge37_row got=%0d exp=7", bus.slot_row); end
    bus.slot_index = 3'd1; #1;
    checks++; if (bus.slot_data !== mk_word(63, 8'h30, 8'h00)) begin
      failures++; $display("FAIL edge37_entry63 got=%h exp=%h", bus.slot_data, mk_word(63, 8'h30, 8'h00));
    end
    // One past the bottom of an 8-row sprite.
    start_scan(8'h38, 1'b0, k);
    wait_done(k, lat);
    checks++; if (bus.sprite_count !== 4'd0) begin failures++; $display("FAIL edge38_short_count got=%0d exp=0", bus.sprite_count); end
    // Same line with 16-row sprites.
    start_scan(8'h38, 1'b1, k);
    wait_done(k, lat);
    checks++; if (bus.sprite_count !== 4'd2) begin failures++; $display("FAIL edge38_tall_count got=%0d exp=2", bus.sprite_count); end
    bus.slot_index = 3'd0; #1;
    checks++; if (bus.slot_row !== 4'd8) begin failures++; $display("FAIL edge38_tall_row got=%0d exp=8", bus.slot_row); end
    // No wrap from y=0xFF to line 0.
    fill_oam(8'hF0);
    oam_mem[0] = mk_word(0, 8'hFF, 8'h00);
    start_scan(8'h00, 1'b1, k);
    wait_done(k, lat);
    checks++; if (bus.sprite_count !== 4'd0) begin failures++; $display("FAIL wrap_count got=%0d exp=0", bus.sprite_count); end
  endtask

  task automatic test_vflip;
    int k, lat;
    logic [3:0] exp_short;
    logic [3:0] exp_tall;
`ifdef OAM_SCAN_VFLIP_EN
    exp_short = 4'd5;
    exp_tall  = 4'd13;
`else
    exp_short = 4'd2;
    exp_tall  = 4'd2;
`endif
    fill_oam(8'hF0);
    oam_mem[7] = mk_word(7, 8'h20, 8'h80);
    start_scan(8'h22, 1'b0, k);
    wait_done(k, lat);
    bus.slot_index = 3'd0; #1;
    checks++; if (bus.sprite_count !== 4'd1) begin failures++; $display("FAIL vflip_count got=%0d exp=1", bus.sprite_count); end
    checks++; if (bus.slot_row !== exp_short) begin failures++; $display("FAIL vflip_row8 got=%0d exp=%0d", bus.slot_row, exp_short); end
    start_scan(8'h22, 1'b1, k);
    wait_done(k, lat);
    bus.slot_index = 3'd0; #1;
    checks++; if (bus.slot_row !== exp_tall) begin failures++; $display("FAIL vflip_row16 got=%0d exp=%0d", bus.slot_row, exp_tall); end
  endtask

  task automatic test_reset_mid_scan;
    int k, lat, dones;
    setup_three();
    start_scan(8'h25, 1'b0, k);
    while (cyc < k + 29) @(negedge clk);
    reset = 1'b1;
    #1;
    bus.slot_index = 3'd0;
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.oam_read_addr !== 6'd0) begin
      failures++; $display("FAIL midrst_ctrl got=busy%b done%b addr%0d exp=busy0 done0 addr0", bus.busy, bus.done, bus.oam_read_addr);
    end
    checks++; if (bus.sprite_count !== 4'd0 || bus.overflow !== 1'b0) begin
      failures++; $display("FAIL midrst_count got=%0d/%b exp=0/0", bus.sprite_count, bus.overflow);
    end
    checks++; if (bus.slot_data !== 32'h0 || bus.slot_row !== 4'd0) begin
      failures++; $display("FAIL midrst_slot0 got=%h/%0d exp=0/0", bus.slot_data, bus.slot_row);
    end
    dones = 0;
    repeat (2) begin @(negedge clk); if (bus.done === 1'b1) dones++; end
    reset = 1'b0;
    repeat (80) begin @(negedge clk); if (bus.done === 1'b1) dones++; end
    checks++; if (dones !== 0) begin failures++; $display("FAIL midrst_no_done got=%0d exp=0", dones); end
    start_scan(8'h25, 1'b0, k);
    wait_done(k, lat);
    checks++; if (lat !== 66 || bus.sprite_count !== 4'd3) begin
      failures++; $display("FAIL midrst_rescan got=lat%0d cnt%0d exp=lat66 cnt3", lat, bus.sprite_count);
    end
  endtask

  task automatic test_back_to_back;
    int k, lat, dones;
    setup_three();
    start_scan(8'h25, 1'b0, k);
    while (cyc < k + 9) @(negedge clk);
    bus.start    = 1'b1;
    bus.scanline = 8'h00;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(k, lat);
    checks++; if (lat !== 66) begin failures++; $display("FAIL b2b_latency got=%0d exp=66", lat); end
    checks++; if (bus.sprite_count !== 4'd3) begin failures++; $display("FAIL b2b_count got=%0d exp=3", bus.sprite_count); end
    dones = 0;
    repeat (100) begin @(negedge clk); if (bus.done === 1'b1) dones++; end
    checks++; if (dones !== 0 || bus.busy !== 1'b0) begin
      failures++; $display("FAIL b2b_single_done got=extra%0d busy%b exp=extra0 busy0", dones, bus.busy);
    end
  endtask

  initial begin
    test_reset();
    test_no_hits();
    test_three_hits();
    test_overflow();
    test_edges();
    test_vflip();
    test_reset_mid_scan();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
